// File: rtl/seq_detector_param.sv
// ============================================================================
// Module   : seq_detector_param
// Purpose  : Runtime-programmable Moore serial-pattern detector with overlap
//            mode and optional saturating match counter (MATCH_CNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_param #(
  parameter int unsigned          MAX_LEN     = 8,
  parameter logic [MAX_LEN-1:0]   DEF_PATTERN = 8'b00001011,
  parameter int unsigned          DEF_LEN     = 4,
  parameter bit                   DEF_OVERLAP = 1'b1,
  parameter int unsigned          CNT_W       = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic                         in,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN):0]     cfg_len,
  input  logic                         cfg_overlap,
  output logic                         cfg_err,
  output logic                         det
`ifdef MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]             match_cnt
`endif
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN) + 1;
  localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] c_DEF_LEN = LEN_W'(DEF_LEN);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_HUNT  = 2'd2,
    S_MATCH = 2'd3
  } state_t;

  state_t               r_state,   w_state_n;
  logic [MAX_LEN-1:0]   r_pattern, w_pattern_n;
  logic [LEN_W-1:0]     r_len,     w_len_n;
  logic                 r_overlap, w_overlap_n;
  logic [MAX_LEN-1:0]   r_hist,    w_hist_n;
  logic [LEN_W-1:0]     r_fill,    w_fill_n;
  logic                 r_cfg_err, w_cfg_err_n;

  logic [MAX_LEN-1:0]   w_hist_shift;
  logic [MAX_LEN-1:0]   w_mask;
  logic [LEN_W-1:0]     w_fill_inc;
  logic                 w_accept;
  logic                 w_cfg_len_ok;
  logic                 w_match;

  assign w_accept     = in_valid & ~cfg_load;
  assign w_cfg_len_ok = (cfg_len != '0) && (cfg_len <= c_MAX_LEN);
  assign w_hist_shift = {r_hist[MAX_LEN-2:0], in};
  assign w_fill_inc   = (r_fill == c_MAX_LEN) ? r_fill : r_fill + 1'b1;

  // Only the low len bits of history and pattern take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_match = w_accept && (w_fill_inc >= r_len) &&
                   (((w_hist_shift ^ r_pattern) & w_mask) == '0);

  always_comb begin
    w_state_n   = r_state;
    w_pattern_n = r_pattern;
    w_len_n     = r_len;
    w_overlap_n = r_overlap;
    w_hist_n    = r_hist;
    w_fill_n    = r_fill;
    w_cfg_err_n = 1'b0;

    if (cfg_load) begin
      if (w_cfg_len_ok) begin
        w_pattern_n = cfg_pattern;
        w_len_n     = cfg_len;
        w_overlap_n = cfg_overlap;
        w_hist_n    = '0;
        w_fill_n    = '0;
        w_state_n   = S_EMPTY;
      end else begin
        w_cfg_err_n = 1'b1;
      end
    end else if (in_valid) begin
      w_hist_n = w_hist_shift;
      if (w_match) begin
        w_state_n = S_MATCH;
        // Non-overlap: forget the consumed bits so the next hit needs len fresh ones.
        w_fill_n  = r_overlap ? w_fill_inc : '0;
      end else begin
        w_fill_n  = w_fill_inc;
        w_state_n = (w_fill_inc >= r_len) ? S_HUNT : S_FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_EMPTY;
      r_pattern <= DEF_PATTERN;
      r_len     <= c_DEF_LEN;
      r_overlap <= DEF_OVERLAP;
      r_hist    <= '0;
      r_fill    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_pattern <= w_pattern_n;
      r_len     <= w_len_n;
      r_overlap <= w_overlap_n;
      r_hist    <= w_hist_n;
      r_fill    <= w_fill_n;
      r_cfg_err <= w_cfg_err_n;
    end
  end

  assign det     = (r_state == S_MATCH);
  assign cfg_err = r_cfg_err;

`ifdef MATCH_CNT_EN
  logic [CNT_W-1:0] r_match_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_match_cnt <= '0;
    end else if (cfg_load && w_cfg_len_ok) begin
      r_match_cnt <= '0;
    end else if (w_match && (r_match_cnt != '1)) begin
      r_match_cnt <= r_match_cnt + 1'b1;
    end
  end

  assign match_cnt = r_match_cnt;
`endif

endmodule

`default_nettype wire
